// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with EX/WB operand forwarding,
// load-use bubble insertion, flush and valid/ready back-pressure.
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [RA_W-1:0]  in_rs1_addr,
    input  logic [RA_W-1:0]  in_rs2_addr,
    input  logic [RA_W-1:0]  in_rd_addr,
    input  logic             in_uses_rs2,
    input  logic             in_alu_src,
    input  logic             in_ctrl,
    input  logic             in_reg_write,
    input  logic             in_mem_read,
    input  logic             in_mem_write,
    input  logic             ex_fwd_en,
    input  logic [RA_W-1:0]  ex_fwd_rd,
    input  logic [XLEN-1:0]  ex_fwd_data,
    input  logic             wb_fwd_en,
    input  logic [RA_W-1:0]  wb_fwd_rd,
    input  logic [XLEN-1:0]  wb_fwd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_in_1,
    output logic [XLEN-1:0]  out_in_2,
    output logic             out_ctrl,
    output logic [XLEN-1:0]  out_store_data,
    output logic [RA_W-1:0]  out_rd_addr,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic [CNT_W-1:0] stall_count
);
    logic            full, alu_src, ctrl, reg_write, mem_read, mem_write;
    logic [XLEN-1:0] rs1_v, rs2_v, imm, rs1_r, rs2_r;
    logic [RA_W-1:0] rs1_a, rs2_a, rd_a;
    logic            hz, accept;

    assign hz = full && mem_read && rd_a != '0 &&
                (rd_a == in_rs1_addr || (in_uses_rs2 && rd_a == in_rs2_addr));
    assign in_ready = !rst && !flush && !hz && (!full || out_ready);
    assign accept = in_valid && in_ready;
    assign out_valid = full;

    // EX result is newer than WB, so it wins; x0 is hardwired and never forwarded
    assign rs1_r = (ex_fwd_en && rs1_a != '0 && ex_fwd_rd == rs1_a) ? ex_fwd_data :
                   (wb_fwd_en && rs1_a != '0 && wb_fwd_rd == rs1_a) ? wb_fwd_data : rs1_v;
    assign rs2_r = (ex_fwd_en && rs2_a != '0 && ex_fwd_rd == rs2_a) ? ex_fwd_data :
                   (wb_fwd_en && rs2_a != '0 && wb_fwd_rd == rs2_a) ? wb_fwd_data : rs2_v;

    assign out_in_1       = full ? rs1_r : '0;
    assign out_in_2       = full ? (alu_src ? imm : rs2_r) : '0;
    assign out_store_data = full ? rs2_r : '0;
    assign out_ctrl       = full && ctrl;
    assign out_rd_addr    = full ? rd_a : '0;
    assign out_reg_write  = full && reg_write;
    assign out_mem_read   = full && mem_read;
    assign out_mem_write  = full && mem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            full        <= 1'b0;
            rs1_v       <= '0;
            rs2_v       <= '0;
            imm         <= '0;
            rs1_a       <= '0;
            rs2_a       <= '0;
            rd_a        <= '0;
            alu_src     <= 1'b0;
            ctrl        <= 1'b0;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            stall_count <= '0;
        end else begin
            if (flush)
                full <= 1'b0;
            else if (accept)
                full <= 1'b1;
            else if (out_ready)
                full <= 1'b0;
            if (accept) begin
                // WB writes the register file this cycle, so its value is newer than the read data
                rs1_v     <= (wb_fwd_en && wb_fwd_rd != '0 && wb_fwd_rd == in_rs1_addr) ? wb_fwd_data : in_rs1_data;
                rs2_v     <= (wb_fwd_en && wb_fwd_rd != '0 && wb_fwd_rd == in_rs2_addr) ? wb_fwd_data : in_rs2_data;
                imm       <= in_imm;
                rs1_a     <= in_rs1_addr;
                rs2_a     <= in_rs2_addr;
                rd_a      <= in_rd_addr;
                alu_src   <= in_alu_src;
                ctrl      <= in_ctrl;
                reg_write <= in_reg_write;
                mem_read  <= in_mem_read;
                mem_write <= in_mem_write;
            end
            if (in_valid && hz && !flush && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage covering forwarding, load-use,
// back-pressure, flush and immediate operand selection.
module tb_id_ex_stage;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [63:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
    logic [4:0]  in_rs1_addr = '0, in_rs2_addr = '0, in_rd_addr = '0;
    logic        in_uses_rs2 = 1'b0, in_alu_src = 1'b0, in_ctrl = 1'b0;
    logic        in_reg_write = 1'b0, in_mem_read = 1'b0, in_mem_write = 1'b0;
    logic        ex_fwd_en = 1'b0, wb_fwd_en = 1'b0;
    logic [4:0]  ex_fwd_rd = '0, wb_fwd_rd = '0;
    logic [63:0] ex_fwd_data = '0, wb_fwd_data = '0;
    logic        out_valid, out_ready = 1'b1, out_ctrl;
    logic [63:0] out_in_1, out_in_2, out_store_data;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write, out_mem_read, out_mem_write;
    logic [31:0] stall_count;

    typedef struct packed {
        logic [63:0] in1, in2, st;
        logic [8:0]  ctl;
    } exp_t;
    exp_t q[$];
    int   n_chk = 0, n_pass = 0;
    bit   acc;
    logic [63:0] hold1;
    int   j;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_uses_rs2(in_uses_rs2), .in_alu_src(in_alu_src), .in_ctrl(in_ctrl),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .ex_fwd_en(ex_fwd_en), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_in_1(out_in_1), .out_in_2(out_in_2), .out_ctrl(out_ctrl),
        .out_store_data(out_store_data), .out_rd_addr(out_rd_addr),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] byp(input logic [4:0] a, input logic [63:0] d);
        return (wb_fwd_en && wb_fwd_rd != 0 && wb_fwd_rd == a) ? wb_fwd_data : d;
    endfunction

    task automatic set_in(input logic [4:0] a1, input logic [63:0] d1,
                          input logic [4:0] a2, input logic [63:0] d2, input logic [4:0] rd);
        in_valid = 1'b1; in_rs1_addr = a1; in_rs1_data = d1; in_rs2_addr = a2; in_rs2_data = d2;
        in_rd_addr = rd; in_imm = '0; in_uses_rs2 = 1'b1; in_alu_src = 1'b0; in_ctrl = 1'b0;
        in_reg_write = 1'b1; in_mem_read = 1'b0; in_mem_write = 1'b0;
    endtask

    // one clock: retire a departing instruction against the queue, record an accepted one
    task automatic cyc(output bit a);
        exp_t e;
        #1;
        a = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("sb_empty", 1, 0);
            else begin
                e = q.pop_front();
                chk("in1", out_in_1, e.in1);
                chk("in2", out_in_2, e.in2);
                chk("store", out_store_data, e.st);
                chk("ctl", {out_ctrl, out_rd_addr, out_reg_write, out_mem_read, out_mem_write}, e.ctl);
            end
        end
        if (a) begin
            e.in1 = byp(in_rs1_addr, in_rs1_data);
            e.st  = byp(in_rs2_addr, in_rs2_data);
            e.in2 = in_alu_src ? in_imm : e.st;
            e.ctl = {in_ctrl, in_rd_addr, in_reg_write, in_mem_read, in_mem_write};
            q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        set_in(1, 5, 2, 3, 3);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_in1", out_in_1, 0);
        rst = 1'b0;
        in_ctrl = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 1);
        cyc(acc);
        in_valid = 1'b0;
        chk("basic_valid", out_valid, 1);
        chk("basic_ctrl", out_ctrl, 1);
        cyc(acc);
        chk("bubble_in1", out_in_1, 0);

        // forwarding priority on a held instruction
        set_in(7, 1, 2, 0, 8);
        cyc(acc);
        in_valid = 1'b0;
        ex_fwd_en = 1'b1; ex_fwd_rd = 7; ex_fwd_data = 100;
        wb_fwd_en = 1'b1; wb_fwd_rd = 7; wb_fwd_data = 200;
        #1 chk("fwd_ex", out_in_1, 100);
        ex_fwd_en = 1'b0;
        #1 chk("fwd_wb", out_in_1, 200);
        wb_fwd_en = 1'b0;
        cyc(acc);
        set_in(0, 1, 2, 0, 8);
        cyc(acc);
        in_valid = 1'b0;
        ex_fwd_en = 1'b1; ex_fwd_rd = 0; wb_fwd_en = 1'b1; wb_fwd_rd = 0;
        #1 chk("fwd_x0", out_in_1, 1);
        ex_fwd_en = 1'b0; wb_fwd_en = 1'b0;
        cyc(acc);

        // load-use: one bubble, then dependent sees load data via WB
        set_in(1, 11, 2, 0, 4);
        in_mem_read = 1'b1;
        cyc(acc);
        set_in(4, 0, 9, 5, 10);
        #1 chk("lu_in_ready", in_ready, 0);
        cyc(acc);
        chk("lu_stall", stall_count, 1);
        chk("lu_bubble", out_valid, 0);
        chk("lu_ready_again", in_ready, 1);
        cyc(acc);
        in_valid = 1'b0;
        wb_fwd_en = 1'b1; wb_fwd_rd = 4; wb_fwd_data = 64'h77;
        #1 chk("lu_wb_fwd", out_in_1, 64'h77);
        wb_fwd_en = 1'b0;
        cyc(acc);

        // capture-time WB bypass
        wb_fwd_en = 1'b1; wb_fwd_rd = 12; wb_fwd_data = 64'h55;
        set_in(12, 3, 13, 4, 14);
        cyc(acc);
        wb_fwd_en = 1'b0; in_valid = 1'b0;
        cyc(acc);

        // back-pressure over a stream
        j = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = !(c >= 2 && c < 5);
            if (j < 6) begin
                set_in(5'(1 + j), 64'(100 + j), 5'(2 + j), 64'(200 + j), 5'(10 + j));
                in_ctrl = j[0];
            end else in_valid = 1'b0;
            #1;
            if (c >= 3 && c < 5) begin
                chk("bp_in_ready", in_ready, 0);
                chk("bp_stable", out_in_1, hold1);
            end
            hold1 = out_in_1;
            cyc(acc);
            if (acc) j++;
        end
        chk("bp_all_sent", j, 6);
        chk("bp_drained", q.size(), 0);

        // stall while blocked, then flush mid-stall
        set_in(1, 1, 2, 0, 6);
        in_mem_read = 1'b1;
        cyc(acc);
        out_ready = 1'b0;
        set_in(3, 0, 6, 2, 7);
        cyc(acc);
        chk("stall_blocked", stall_count, 2);
        flush = 1'b1;
        #1 chk("flush_in_ready", in_ready, 0);
        cyc(acc);
        flush = 1'b0;
        void'(q.pop_front());
        chk("flush_out_valid", out_valid, 0);
        chk("flush_stall", stall_count, 2);
        #1 chk("flush_ready_again", in_ready, 1);
        out_ready = 1'b1;
        cyc(acc);
        in_valid = 1'b0;
        cyc(acc);

        // immediate operand with forwarded store data
        set_in(1, 5, 6, 0, 0);
        in_alu_src = 1'b1; in_imm = 64'hFFFF_FFFF_FFFF_FFF8; in_reg_write = 1'b0; in_mem_write = 1'b1;
        cyc(acc);
        in_valid = 1'b0;
        ex_fwd_en = 1'b1; ex_fwd_rd = 6; ex_fwd_data = 9;
        #1;
        chk("imm_in2", out_in_2, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("imm_store", out_store_data, 9);
        ex_fwd_en = 1'b0;
        cyc(acc);
        cyc(acc);
        chk("final_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the RISC-V core, sitting directly upstream of the ALU. It holds one decoded instruction and presents the two ALU operands and the 1-bit ALU control. Operands are resolved through EX and WB forwarding. The stage also detects load-use hazards, inserting exactly one bubble, and honours a flush from branch resolution. A valid/ready handshake on both sides allows back-pressure from later stages.

## Interface
- XLEN, 64, datapath width (matches ALU operand width)
- RA_W, 5, register address width
- CNT_W, 32, stall counter width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  drop held instruction and refuse input this cycle
- in_valid / in_ready  in / out  1  decode-side handshake
- in_rs1_data, in_rs2_data, in_imm  in  XLEN  register-file operands, sign-extended immediate
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  RA_W  source/destination registers
- in_uses_rs2  in  1  instruction reads rs2 (R-type, store, branch)
- in_alu_src  in  1  1: ALU in_2 = imm; 0: ALU in_2 = rs2
- in_ctrl  in  1  ALU op: 0 add, 1 sub
- in_reg_write, in_mem_read, in_mem_write  in  1  control bits
- ex_fwd_en, wb_fwd_en  in  1  forward source valid (downstream drives ex_fwd_en low for loads/bubbles)
- ex_fwd_rd, wb_fwd_rd  in  RA_W  forward destination
- ex_fwd_data, wb_fwd_data  in  XLEN  forward value
- out_valid / out_ready  out / in  1  execute-side handshake
- out_in_1, out_in_2  out  XLEN  ALU operands
- out_ctrl  out  1  ALU control
- out_store_data  out  XLEN  forwarded rs2 for stores
- out_rd_addr  out  RA_W; out_reg_write, out_mem_read, out_mem_write  out  1
- stall_count  out  CNT_W  saturating count of load-use stall cycles

## Operation
- State: `full` flag plus held fields (rs1/rs2 values, imm, addresses, uses_rs2, alu_src, ctrl, control bits). out_valid = full.
- Hazard: hz = full & held mem_read & held rd ≠ 0 & (held rd == in_rs1_addr | (in_uses_rs2 & held rd == in_rs2_addr)).
- in_ready = !rst & !flush & !hz & (!full | out_ready).
- Accept (in_valid & in_ready): latch all inputs; full ← 1. Capture-time bypass: if wb_fwd_en, wb_fwd_rd ≠ 0 and it matches rs1/rs2, latch wb_fwd_data instead of register-file data.
- Depart without accept (out_valid & out_ready & no accept): full ← 0. Simultaneous depart+accept: full stays 1, new instruction replaces old.
- flush: full ← 0 regardless of out_ready; no accept.
- Operand resolution (combinational on held values), per source r:
  - if ex_fwd_en & ex_fwd_rd == r & r ≠ 0: ex_fwd_data;
  - else if wb_fwd_en & wb_fwd_rd == r & r ≠ 0: wb_fwd_data;
  - else: held value.
  - EX has priority over WB. x0 is never forwarded.
- out_in_1 = resolved rs1; out_store_data = resolved rs2; out_in_2 = alu_src ? imm : resolved rs2.
- When !full, all out_* data/control outputs are 0 (bubble: reg_write/mem_* low).
- stall_count increments when in_valid & hz & !flush; saturates at all-ones.

## Timing
- rst: full=0, all outputs 0, stall_count=0, in_ready=0 during reset cycle.
- Latency: accepted at edge k → out_valid from cycle k+1.
- Throughput 1/cycle when out_ready held high.
- Load-use: load held in cycle t, dependent presented. in_ready=0 in t; load departs at end of t; stage empty in t+1 (bubble); dependent accepted end of t+1. In t+2, load data arrives via wb_fwd.
- out_ready low: held fields and out_* stable; in_ready=0 if full.
- flush and rst mid-stall: stage empties next cycle, stall_count unchanged by flush cycle.

## Test plan
- Reset then in_valid with rs1=5, rs2=3, ctrl=1, alu_src=0 → next cycle out_valid=1, out_in_1=5, out_in_2=3, out_ctrl=1.
- Held rs1=x7 (reg value 1), ex_fwd (x7, 100) and wb_fwd (x7, 200) both active → out_in_1=100; drop ex_fwd → 200; same with rd=x0 → 1.
- Load to x4 held, next instr uses x4 as rs1 → in_ready=0 one cycle, one bubble with out_valid=0, stall_count=1, then dependent accepted.
- out_ready=0 for 3 cycles with valid input stream → outputs stable, in_ready=0, no instruction lost or duplicated.
- flush while full and in_valid=1 → next cycle out_valid=0, input not accepted; in_ready high again the following cycle.
- alu_src=1, imm=-8 (0xFFFF_FFFF_FFFF_FFF8), rs2 forwarded=9 → out_in_2=imm, out_store_data=9.
